// File: rtl/wburst_pkg.sv
// Shared types and constants for the write-burst issuer.
package wburst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wburst_outstanding_ctr.sv
// Saturating up/down counter of AW bursts still waiting for their B response.
// An increment and an accepted decrement in the same cycle cancel out; a
// decrement while empty is dropped, so the count can never underflow.
module wburst_outstanding_ctr #(
  parameter int MAX_COUNT = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic dec_ok
);

  logic [CNT_W-1:0] count;
  logic             inc_ok;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(MAX_COUNT));
  assign dec_ok = dec & ~empty;
  assign inc_ok = inc & (~full | dec_ok);

  // Net count update; simultaneous accepted inc/dec leaves the count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc_ok && !dec_ok) begin
      count <= count + CNT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/wburst_issuer.sv
// Write-burst issuer: turns ready bursts from the burst counter into AXI4
// AW + W transactions and tracks B responses until the job completes.
// Optional build macro WBURST_BRESP_CHECK_EN adds sticky BRESP error
// reporting (bresp_err / bresp_err_addr).
//
//  state | meaning
//  IDLE  | waiting for an available burst with room for another outstanding B
//  ADDR  | AWVALID up, address/length held until AWREADY
//  DATA  | streaming beats 0..len from the data buffer, WLAST on beat len
module wburst_issuer
  import wburst_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int WBURST_LEN      = 4,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [AXI_ADDR_WIDTH-1:0]     base_addr,
  output logic                          done,
  input  logic                          wburst_ready,
  input  logic [WBURST_LEN-1:0]         wburst_len,
  output logic                          wburst_issued,
  output logic [WBURST_LEN-1:0]         wburst_issued_len,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata,
  input  logic                          wdata_valid,
  output logic                          wdata_pop,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
`ifdef WBURST_BRESP_CHECK_EN
  ,
  output logic                          bresp_err,
  output logic [AXI_ADDR_WIDTH-1:0]     bresp_err_addr
`endif
);

  localparam int BYTES     = AXI_DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = clog2(BYTES);
  localparam int CNT_W     = clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_W    = (clog2(MAX_BURST_LEN) > WBURST_LEN) ? clog2(MAX_BURST_LEN) : WBURST_LEN;

  wb_state_t                 state;
  logic [WBURST_LEN-1:0]     len_q;
  logic [BEAT_W-1:0]         beat;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ADDR_WIDTH-1:0] burst_bytes;
  logic                      issued_any;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      last_beat;
  logic                      out_full;
  logic                      out_empty;
  logic                      b_taken;
  logic                      start_ok;

  assign aw_hs       = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs        = M_AXI_WVALID & M_AXI_WREADY;
  assign last_beat   = (beat == BEAT_W'(len_q));
  assign start_ok    = start & (state == IDLE);
  assign burst_bytes = (AXI_ADDR_WIDTH'(len_q) + AXI_ADDR_WIDTH'(1)) << SIZE_LOG2;

  assign wburst_issued     = aw_hs;
  assign wburst_issued_len = len_q;
  assign M_AXI_AWLEN       = 8'(len_q);
  assign M_AXI_AWSIZE      = 3'(SIZE_LOG2);
  assign M_AXI_AWBURST     = AXI_BURST_INCR;
  assign M_AXI_WDATA       = wdata;
  assign M_AXI_WSTRB       = '1;
  assign M_AXI_WVALID      = (state == DATA) & wdata_valid;
  assign M_AXI_WLAST       = (state == DATA) & last_beat;
  assign M_AXI_BREADY      = 1'b1;
  assign wdata_pop         = w_hs;

  wburst_outstanding_ctr #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .CNT_W     (CNT_W)
  ) u_outstanding (
    .clk    (clk),
    .reset  (reset),
    .inc    (aw_hs),
    .dec    (M_AXI_BVALID),
    .full   (out_full),
    .empty  (out_empty),
    .dec_ok (b_taken)
  );

  // Burst sequencing: latch length, present AW, then stream the W beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_AWADDR  <= '0;
      len_q         <= '0;
      beat          <= '0;
      addr_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= base_addr;
          end else if (!done && wburst_ready && !out_full) begin
            len_q         <= wburst_len;
            M_AXI_AWADDR  <= addr_q;
            M_AXI_AWVALID <= 1'b1;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            addr_q        <= addr_q + burst_bytes;
            beat          <= '0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (last_beat) state <= IDLE;
            else           beat  <= beat + BEAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Job completion: done only once the job has issued something and drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      done       <= 1'b1;
      issued_any <= 1'b0;
    end else if (start_ok) begin
      done       <= 1'b0;
      issued_any <= 1'b0;
    end else begin
      if (aw_hs) issued_any <= 1'b1;
      if (state == IDLE && out_empty && !wburst_ready && issued_any) done <= 1'b1;
    end
  end

`ifdef WBURST_BRESP_CHECK_EN
  // B responses return in issue order, so a small address ring pairs each
  // accepted B with the AWADDR of the burst it completes.
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? clog2(MAX_OUTSTANDING) : 1;

  logic [AXI_ADDR_WIDTH-1:0] addr_ring [MAX_OUTSTANDING];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;

  // Ring bookkeeping plus sticky capture of the first failing burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bresp_err      <= 1'b0;
      bresp_err_addr <= '0;
    end else begin
      if (aw_hs) begin
        addr_ring[wr_ptr] <= M_AXI_AWADDR;
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (b_taken) begin
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (start_ok) begin
        bresp_err <= 1'b0;
      end else if (b_taken && M_AXI_BRESP != AXI_RESP_OKAY && !bresp_err) begin
        bresp_err      <= 1'b1;
        bresp_err_addr <= addr_ring[rd_ptr];
      end
    end
  end
`else
  logic [1:0] unused_bresp;
  logic       unused_b_taken;
  assign unused_bresp   = M_AXI_BRESP;
  assign unused_b_taken = b_taken;
`endif

endmodule
